pc_fetch: RTL
=============

# pc_fetch

Fetch-stage sequencer for the pipelined RV32I core. Holds the program counter, drives the instruction-memory address and owns the IF/ID pipeline register. Consumes the `NPCOp` redirect encoding that the control decoder produces, resolved in EX, and computes branch, JAL and JALR targets. Squashes wrong-path instructions on a redirect and freezes on hazard-unit stalls.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `stall  in  1`: load-use stall from the hazard unit; holds the PC and IF/ID.
- `ex_NPCOp  in  5`: redirect request from EX.
  - 5'b00000: plus4
  - 5'b00001: branch taken
  - 5'b00010: JAL
  - 5'b00100: JALR
- `ex_pc  in  32`: PC of the EX-stage instruction.
- `ex_imm  in  32`: sign-extended immediate of the EX-stage instruction.
- `ex_rs1  in  32`: forwarded rs1 value in EX, used by JALR.
- `imem_rdata  in  32`: instruction word at `imem_addr`, combinational read.
- `imem_addr  out  32`: current PC, equal to the `pc` register.
- `if_id_pc  out  32`: PC of the instruction held in IF/ID.
- `if_id_inst  out  32`: instruction held in IF/ID.
- `if_id_valid  out  1`: IF/ID holds a real, non-squashed instruction.
- `flush  out  1`: combinational; high while a redirect is taken this cycle. Decode uses it to bubble ID/EX.
- `misalign  out  1`: combinational; the redirect target had `[1:0]` != 0.
- `flush_cnt  out  16`: number of redirects taken since reset.

## Operation
- Redirect decode, priority JALR > JAL > branch:
  - `redir_jalr = ex_NPCOp[2]`
  - `redir_jal = ex_NPCOp[1] & ~ex_NPCOp[2]`
  - `redir_br = ex_NPCOp[0] & ~ex_NPCOp[2:1]`
  - Bits `[4:3]` are ignored.
- `redirect = redir_jalr | redir_jal | redir_br`; `flush = redirect`.
- Targets use 32-bit modulo arithmetic; carry is discarded and results wrap at 2^32.
  - Branch and JAL: `ex_pc + ex_imm`.
  - JALR: `(ex_rs1 + ex_imm) & ~32'h1`.
- Misalignment: `misalign = redirect & (raw_target[1:0] != 0)`.
  - The PC loads `{raw_target[31:2], 2'b00}`.
  - No trap is raised.
- Next-PC selection, in priority order:
  1. `redirect`: target.
  2. `stall`: hold.
  3. Otherwise: `pc + 4`, wrapping from 32'hFFFF_FFFC to 32'h0.
- IF/ID update, in priority order:
  1. `redirect`: `if_id_valid` = 0, `if_id_inst` = 32'h0000_0013 (NOP), `if_id_pc` = 0.
  2. `stall`: hold all three fields.
  3. Otherwise: `if_id_inst` = `imem_rdata`, `if_id_pc` = `pc`, `if_id_valid` = 1.
- Redirect and stall in the same cycle: the redirect wins. The stalled instruction is on the wrong path and is squashed.
- `flush_cnt` increments by 1 on each edge where `redirect` = 1 and wraps 16'hFFFF to 0.
- Internal state machine:
  - States: BOOT, RUN.
  - BOOT: entered on reset. Lasts exactly one cycle. The fetch of `RESET_PC` is captured into IF/ID at its end, then the machine moves to RUN.
  - RUN: steady-state operation. Leaves RUN only on reset.
  - A redirect in BOOT follows the same rules as in RUN.

## Timing
- Reset values:
  - `pc` = `RESET_PC`, so `imem_addr` = `RESET_PC`.
  - `if_id_pc` = 0, `if_id_inst` = 32'h0000_0013, `if_id_valid` = 0.
  - `flush_cnt` = 0, state = BOOT.
  - `flush` and `misalign` follow their inputs combinationally.
- Reset is asynchronous: outputs take reset values immediately on `rst` rising, including mid-redirect or mid-stall. No partial update survives.
- Fetch latency: 1 cycle from `imem_addr` to IF/ID.
- Redirect sampled at edge N:
  - `imem_addr` = target from cycle N+1.
  - Target instruction is valid in IF/ID from cycle N+2.
  - Exactly one wrong-path fetch is squashed in IF/ID. The ID/EX instruction is squashed by decode using `flush`.
  - Penalty: 2 cycles.
- Stall held for k cycles: PC and IF/ID are frozen for k edges; no instruction is lost or duplicated.
- Back-to-back redirects on consecutive cycles: each one is honoured and `flush_cnt` increments twice.

## Test plan
- Reset and sequential fetch:
  - Stimulus: `RESET_PC`=32'h100, `rst` released, no redirects.
  - Response: `imem_addr` sequence 100, 104, 108. At each edge IF/ID captures `imem_rdata` and the then-current PC (first capture `if_id_pc`=32'h100), and `if_id_valid` rises after the first edge.
- Taken branch:
  - Stimulus: `ex_NPCOp`=00001, `ex_pc`=32'h200, `ex_imm`=32'hFFFF_FFF0.
  - Response: `flush`=1; next `imem_addr`=32'h1F0; `if_id_valid`=0 with `if_id_inst`=32'h13 for one cycle; `flush_cnt`=1.
- JALR with odd target:
  - Stimulus: `ex_NPCOp`=00100, `ex_rs1`=32'h1001, `ex_imm`=4.
  - Response: next PC 32'h1004 (bit 0 cleared), `misalign`=0.
  - Same case with `ex_imm`=6: `misalign`=1, next PC 32'h1004.
- Stall:
  - Stimulus: `stall`=1 for 3 cycles at PC 32'h40.
  - Response: `imem_addr` stays 32'h40 and IF/ID is unchanged for 3 edges; fetch resumes at 32'h44 afterwards.
- Stall and JAL together:
  - Stimulus: `stall`=1 with `ex_NPCOp`=00010, `ex_pc`=32'h80, `ex_imm`=32'h20.
  - Response: PC=32'hA0, IF/ID squashed.
  - Also: `ex_NPCOp`=00111 selects the JALR target.
- Wrap and reset mid-operation:
  - Stimulus: PC=32'hFFFF_FFFC with no stall or redirect.
  - Response: next PC 32'h0.
  - Stimulus: assert `rst` while `flush`=1.
  - Response: immediate reset values and `flush_cnt`=0.

Source files
------------

// File: rtl/pc_fetch.sv
// pc_fetch: fetch-stage PC sequencer with EX-resolved redirects, stall hold and the IF/ID register
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [4:0]  ex_NPCOp,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic        flush,
  output logic        misalign,
  output logic [15:0] flush_cnt
);
  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [0:0]  state;
  logic [31:0] pc, raw_target;
  logic        redir_jalr, redir_jal, redir_br, redirect, hold;
  // masking the whole encoding keeps the ignored upper bits out of the decode
  assign redir_jalr = |(ex_NPCOp & 5'b00100);
  assign redir_jal  = (ex_NPCOp & 5'b00110) == 5'b00010;
  assign redir_br   = (ex_NPCOp & 5'b00111) == 5'b00001;
  assign redirect   = redir_jalr | redir_jal | redir_br;
  assign raw_target = redir_jalr ? (ex_rs1 + ex_imm) & ~32'h1 : ex_pc + ex_imm;
  assign flush      = redirect;
  assign misalign   = redirect & (raw_target[1:0] != 2'b00);
  assign imem_addr  = pc;
  // the boot fetch of RESET_PC is always captured, so stall only bites in RUN
  assign hold       = stall & (state == RUN);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_id_pc    <= 32'h0;
      if_id_inst  <= NOP;
      if_id_valid <= 1'b0;
      flush_cnt   <= 16'h0;
    end else begin
      state <= RUN;
      pc    <= redirect ? {raw_target[31:2], 2'b00} : hold ? pc : pc + 32'd4;
      if (redirect) begin
        if_id_pc    <= 32'h0;
        if_id_inst  <= NOP;
        if_id_valid <= 1'b0;
        flush_cnt   <= flush_cnt + 16'd1;
      end else if (!hold) begin
        if_id_pc    <= pc;
        if_id_inst  <= imem_rdata;
        if_id_valid <= 1'b1;
      end
    end
  end
endmodule
